// File: rtl/i2s_slave_tx.sv
// I2S slave-mode transmitter: a one-pair holding buffer feeds an MSB-first shift register
// that is framed by the externally supplied sck/ws, with underflow flagged when a frame starts empty.
module i2s_slave_tx #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             sck,
  input  logic             reset,
  input  logic             ws,
  input  logic [WIDTH-1:0] sample_left,
  input  logic [WIDTH-1:0] sample_right,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             sd,
  output logic             underflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             ws_q, ws_d;
  logic             synced_q, synced_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] cur_r_q, cur_r_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic             underflow_q, underflow_d;
  logic             fall, rise;

  assign fall = ws_q & ~ws;
  // A rising ws edge only counts once a left slot has established frame alignment.
  assign rise = ~ws_q & ws & synced_q;

  always_comb begin
    ws_d        = ws;
    synced_d    = synced_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    cur_r_d     = cur_r_q;
    shift_d     = shift_q;
    bcnt_d      = bcnt_q;
    underflow_d = 1'b0;

    if (fall) begin
      synced_d = 1'b1;
      bcnt_d   = CW'(1);
      if (hold_full_q) begin
        shift_d     = hold_l_q;
        cur_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d     = '0;
        cur_r_d     = '0;
        underflow_d = 1'b1;
      end
    end else if (rise) begin
      shift_d = cur_r_q;
      bcnt_d  = CW'(1);
    end else if (bcnt_q < CW'(WIDTH)) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      bcnt_d  = bcnt_q + CW'(1);
    end else begin
      shift_d = '0;
    end

    // Accept needs an empty buffer and consume needs a full one, so the two never collide.
    if (sample_valid && !hold_full_q) begin
      hold_l_d    = sample_left;
      hold_r_d    = sample_right;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge sck or negedge reset) begin
    if (!reset) begin
      ws_q        <= 1'b0;
      synced_q    <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      cur_r_q     <= '0;
      shift_q     <= '0;
      bcnt_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      ws_q        <= ws_d;
      synced_q    <= synced_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      cur_r_q     <= cur_r_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign sd           = shift_q[WIDTH-1];
  assign sample_ready = ~hold_full_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_i2s_slave_tx.sv
// Bench for i2s_slave_tx: drives sck/ws framing and sample pairs, checks sd/ready/underflow every cycle
// against a slot-position model, and checks the words a receiver would assemble.
module tb_i2s_slave_tx;

  localparam int unsigned W = 24;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  logic         sck = 1'b0;
  logic         reset = 1'b1;
  logic         ws = 1'b0;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample_left = '0;
  logic [W-1:0] sample_right = '0;
  logic         sample_ready, sd, underflow;

  i2s_slave_tx #(.WIDTH(W)) dut (
    .sck          (sck),
    .reset        (reset),
    .ws           (ws),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sd           (sd),
    .underflow    (underflow)
  );

  always #5 sck = ~sck;

  int checks = 0;
  int failures = 0;

  pair_t        offq[$];
  logic         ws_drv = 1'b0;

  // Reference model state: buffered pair, frame alignment, current word and position within the slot.
  logic         m_wsq = 1'b0;
  logic         m_sync = 1'b0;
  logic         m_pend = 1'b0;
  logic [W-1:0] m_pl = '0, m_pr = '0;
  logic [W-1:0] m_word = '0, m_cur_r = '0;
  int           m_j = W;

  logic [W-1:0] rx_acc = '0;
  int           rx_n = 0;
  logic [W-1:0] rx_last_l = '0, rx_last_r = '0;
  int           uf_seen = 0;
  int           uf0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic fall, rise, was_full, exp_uf, exp_sd;
    @(negedge sck);
    ws = ws_drv;
    sample_valid = (offq.size() > 0);
    if (offq.size() > 0) begin
      sample_left  = offq[0].l;
      sample_right = offq[0].r;
    end
    @(posedge sck);
    fall     = m_wsq && !ws;
    rise     = !m_wsq && ws;
    m_wsq    = ws;
    was_full = m_pend;
    exp_uf   = 1'b0;
    if (fall) begin
      m_sync = 1'b1;
      if (m_pend) begin
        m_word  = m_pl;
        m_cur_r = m_pr;
        m_pend  = 1'b0;
      end else begin
        m_word  = '0;
        m_cur_r = '0;
        exp_uf  = 1'b1;
      end
      m_j = 0;
    end else if (rise && m_sync) begin
      m_word = m_cur_r;
      m_j    = 0;
    end else if (m_j < W) begin
      m_j++;
    end
    if (sample_valid && !was_full) begin
      m_pend = 1'b1;
      m_pl   = sample_left;
      m_pr   = sample_right;
      void'(offq.pop_front());
    end
    #1;
    exp_sd = (m_sync && m_j < W) ? m_word[W-1-m_j] : 1'b0;
    check("sd", 32'(sd), 32'(exp_sd));
    check("sample_ready", 32'(sample_ready), 32'(!m_pend));
    check("underflow", 32'(underflow), 32'(exp_uf));
    if (underflow) uf_seen++;
    if (rx_n < W) begin
      rx_acc = {rx_acc[W-2:0], sd};
      rx_n++;
    end
  endtask

  task automatic run_slot(input logic wsv, input int len);
    logic [W-1:0] word;
    ws_drv = wsv;
    rx_acc = '0;
    rx_n   = 0;
    repeat (len) tick();
    word = rx_acc << (W - rx_n);
    if (wsv) rx_last_r = word;
    else     rx_last_l = word;
  endtask

  task automatic frame(input int ll, input int lr);
    run_slot(1'b0, ll);
    run_slot(1'b1, lr);
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    offq.push_back(p);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_sd", 32'(sd), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_underflow", 32'(underflow), 32'd0);
    @(posedge sck);
    #2 reset = 1'b1;
    m_wsq   = 1'b0;
    m_sync  = 1'b0;
    m_pend  = 1'b0;
    m_word  = '0;
    m_cur_r = '0;
    m_j     = W;
  endtask

  initial begin
    // Power-on reset, ws low, no samples: sync on the first fall, one underflow per frame.
    do_reset();
    run_slot(1'b0, 8);
    run_slot(1'b1, 32);
    check("presync_underflows", 32'(uf_seen), 32'd0);
    repeat (3) frame(32, 32);
    check("idle_underflows", 32'(uf_seen), 32'd3);

    // Single pair buffered ahead of a frame.
    push(24'hA5A5A5, 24'h5A5A5A);
    run_slot(1'b1, 4);
    frame(32, 32);
    check("pair_left", 32'(rx_last_l), 32'h00A5A5A5);
    check("pair_right", 32'(rx_last_r), 32'h005A5A5A);

    // Back-to-back pairs with sample_valid held high.
    uf0 = uf_seen;
    push(24'h800000, 24'h7FFFFF);
    push(24'h000001, 24'hFFFFFF);
    run_slot(1'b1, 4);
    frame(32, 32);
    check("b2b0_left", 32'(rx_last_l), 32'h00800000);
    check("b2b0_right", 32'(rx_last_r), 32'h007FFFFF);
    frame(32, 32);
    check("b2b1_left", 32'(rx_last_l), 32'h00000001);
    check("b2b1_right", 32'(rx_last_r), 32'h00FFFFFF);
    check("b2b_underflows", 32'(uf_seen - uf0), 32'd0);

    // Short 16-bit slots keep only the top 16 bits of each word.
    push(24'hABCDEF, 24'h123456);
    run_slot(1'b1, 4);
    frame(16, 16);
    check("short_left", 32'(rx_last_l), 32'h00ABCD00);
    check("short_right", 32'(rx_last_r), 32'h00123400);
    frame(32, 32);

    // Reset at bit 10 of a left word with a second pair buffered; restart with ws high.
    push(24'h111111, 24'h222222);
    push(24'h333333, 24'h444444);
    run_slot(1'b1, 4);
    run_slot(1'b0, 10);
    check("pre_reset_ready", 32'(sample_ready), 32'd0);
    ws_drv = 1'b1;
    do_reset();
    uf0 = uf_seen;
    push(24'h0F0F0F, 24'hF0F0F0);
    run_slot(1'b1, 32);
    check("resync_right_silent", 32'(rx_last_r), 32'd0);
    check("resync_no_underflow", 32'(uf_seen - uf0), 32'd0);
    frame(32, 32);
    check("resync_left", 32'(rx_last_l), 32'h000F0F0F);
    check("resync_right", 32'(rx_last_r), 32'h00F0F0F0);
    check("resync_underflows", 32'(uf_seen - uf0), 32'd0);

    // Random pairs and slot lengths, checked cycle by cycle against the model.
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 2) != 0) push(W'($urandom), W'($urandom));
      frame(int'($urandom_range(18, 34)), int'($urandom_range(18, 34)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
